// File: rtl/mips_io_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mips_io_pkg
//  Description : Shared constants for the memory-mapped UART transmitter:
//                register offsets, FSM state encoding, STATUS bit indices
//                and the BAUDDIV clamp helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_io_pkg;

    // Register offsets decoded from Ad[3:2]
    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;

    // Transmit FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // STATUS bit positions; bit 4 is reserved and reads 0
    localparam int STAT_FULL   = 0;
    localparam int STAT_EMPTY  = 1;
    localparam int STAT_BUSY   = 2;
    localparam int STAT_OVF    = 3;
    localparam int STAT_IRQ_EN = 5;

    // A divider below 2 cannot produce a sensible bit period
    function automatic logic [15:0] clamp_baud(input logic [15:0] v);
        return (v < 16'd2) ? 16'd2 : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmio_uart_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx_if
//  Description : CPU data-bus side of the UART transmitter (address, store
//                data, store type, select and read data).
//  Revision    : 1.0 - initial release
// ============================================================================
interface mmio_uart_tx_if;
    logic        Sel;
    logic [31:0] Ad;
    logic [31:0] WrData;
    logic [2:0]  MemWr;
    logic [31:0] DM;

    modport master (output Sel, Ad, WrData, MemWr, input  DM);
    modport slave  (input  Sel, Ad, WrData, MemWr, output DM);
endinterface
`default_nettype wire

// File: rtl/sync_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with count-derived full/empty. A push
//                while full is accepted only if a pop happens in the same
//                cycle. Pops on an empty FIFO are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  wire logic                     Clk,
    input  wire logic                     Reset,
    input  wire logic                     push_i,
    input  wire logic [WIDTH-1:0]         wdata_i,
    input  wire logic                     pop_i,
    output logic      [WIDTH-1:0]         rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic      [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge Clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mmio_uart_tx
//  Description : Memory-mapped 8N1 UART transmitter. Stores to TXDATA are
//                queued in a FIFO and serialised on Tx; STATUS and BAUDDIV
//                are readable combinationally on DM.
//                Optional feature macro: MMIO_UART_TX_IRQ_EN (irq_en bit and
//                registered Irq output).
//  Revision    : 1.0 - initial release
// ============================================================================
module mmio_uart_tx
    import mips_io_pkg::*;
#(
    parameter int          DEPTH      = 8,
    parameter logic [15:0] BAUD_RESET = 16'd434
) (
    input  wire logic      Clk,
    input  wire logic      Reset,
    mmio_uart_tx_if.slave  bus,
    output logic           Tx,
    output logic           Irq
);
    logic [1:0]           addr;
    logic                 wr;
    logic                 push;
    logic                 pop;
    logic [7:0]           fifo_rdata;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic                 busy;
    logic                 bit_end;
    logic                 irq_en;
    logic [31:0]          status_word;

    uart_state_e state_q, state_d;
    logic [15:0] cnt_q,    cnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shreg_q,  shreg_d;
    logic [15:0] bdiv_q,   bdiv_d;
    logic        tx_q,     tx_d;
    logic [15:0] baud_q;
    logic        ovf_q;

    assign addr    = bus.Ad[3:2];
    assign wr      = bus.Sel & (bus.MemWr != 3'b000);
    assign push    = wr & (addr == UART_TXDATA);
    assign busy    = (state_q != ST_IDLE);
    assign bit_end = (cnt_q == bdiv_q - 16'd1);
    assign Tx      = tx_q;

    // Address bits outside the decoded window and the upper store data are not used
    logic unused_bits;
    assign unused_bits = ^{bus.Ad[31:4], bus.Ad[1:0], bus.WrData[31:16], fifo_count};

    sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .push_i  (push),
        .wdata_i (bus.WrData[7:0]),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Control registers: BAUDDIV and the sticky overflow flag
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            baud_q <= BAUD_RESET;
            ovf_q  <= 1'b0;
        end else begin
            if (wr && addr == UART_BAUDDIV) baud_q <= clamp_baud(bus.WrData[15:0]);
            if (wr && addr == UART_STATUS)
                ovf_q <= 1'b0;
            else if (push && fifo_full && !pop)
                ovf_q <= 1'b1;
        end
    end

`ifdef MMIO_UART_TX_IRQ_EN
    logic irq_en_q;
    logic irq_q;
    assign irq_en = irq_en_q;
    assign Irq    = irq_q;

    // Interrupt enable and level interrupt: raised once the line is idle and drained
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr && addr == UART_STATUS) irq_en_q <= bus.WrData[5];
            irq_q <= irq_en_q & fifo_empty & ~busy;
        end
    end
`else
    assign irq_en = 1'b0;
    assign Irq    = 1'b0;
`endif

    // Transmit datapath and FSM state register; Tx idles high
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            bdiv_q   <= BAUD_RESET;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            bdiv_q   <= bdiv_d;
            tx_q     <= tx_d;
        end
    end

    // Next-state logic: each level is held for bdiv clocks; frames run back-to-back
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        bdiv_d   = bdiv_q;
        tx_d     = tx_q;
        pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shreg_d = fifo_rdata;
                    bdiv_d  = baud_q;
                    tx_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    cnt_d    = '0;
                    tx_d     = shreg_q[0];
                    bitcnt_d = '0;
                    state_d  = ST_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bitcnt_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = ST_STOP;
                    end else begin
                        shreg_d  = {1'b0, shreg_q[7:1]};
                        tx_d     = shreg_q[1];
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shreg_d = fifo_rdata;
                        bdiv_d  = baud_q;
                        tx_d    = 1'b0;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Read mux: combinational from Ad[3:2], zero when not selected
    always_comb begin
        status_word              = '0;
        status_word[STAT_FULL]   = fifo_full;
        status_word[STAT_EMPTY]  = fifo_empty;
        status_word[STAT_BUSY]   = busy;
        status_word[STAT_OVF]    = ovf_q;
        status_word[STAT_IRQ_EN] = irq_en;
        bus.DM = '0;
        if (bus.Sel) begin
            case (addr)
                UART_STATUS:  bus.DM = status_word;
                UART_BAUDDIV: bus.DM = {16'b0, baud_q};
                default:      bus.DM = '0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_uart_tx
//  Description : Self-checking bench for mmio_uart_tx. Expected line levels
//                come from a frame model (start, 8 data bits LSB first,
//                stop, each held for the latched divider).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_uart_tx;

    localparam logic [31:0] A_TXDATA = 32'h0;
    localparam logic [31:0] A_STATUS = 32'h4;
    localparam logic [31:0] A_BAUD   = 32'h8;
    localparam logic [31:0] A_RSVD   = 32'hC;
`ifdef MMIO_UART_TX_IRQ_EN
    localparam bit IRQ_BUILD = 1'b1;
`else
    localparam bit IRQ_BUILD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic tx;
    logic irq;
    always #5 clk = ~clk;

    mmio_uart_tx_if bus ();

    mmio_uart_tx #(.DEPTH(8), .BAUD_RESET(16'd434)) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus.slave),
        .Tx    (tx),
        .Irq   (irq)
    );

    int checks   = 0;
    int failures = 0;

    logic [7:0] q_bytes[$];
    int         q_bdiv[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.Sel = 1'b1; bus.Ad = a; bus.WrData = d; bus.MemWr = 3'b010;
    endtask

    task automatic bus_idle();
        @(negedge clk);
        bus.Sel = 1'b0; bus.Ad = '0; bus.WrData = '0; bus.MemWr = 3'b000;
    endtask

    task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus.Sel = 1'b1; bus.Ad = a; bus.MemWr = 3'b000;
        #1 d = bus.DM;
        bus.Sel = 1'b0;
        check(tag, d, exp);
    endtask

    // Frame slot j: 0 = start, 1..8 = data LSB first, 9 = stop
    function automatic logic frame_bit(input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j == 9) return 1'b1;
        return b[j-1];
    endfunction

    // Checks Tx/Irq from k edges after the first push until the line is idle again.
    // q_bytes/q_bdiv describe the frames; probe_k optionally samples STATUS.
    task automatic check_stream(input int k0, input bit irq_en, input int probe_k,
                                input logic [31:0] probe_exp);
        int total = 0;
        for (int i = 0; i < q_bdiv.size(); i++) total += 10 * q_bdiv[i];
        for (int k = k0; k <= total + 1; k++) begin
            logic exp_tx;
            if (k == 0 || k == total + 1) begin
                exp_tx = 1'b1;
            end else begin
                int idx = k - 1;
                int off = 0;
                int f   = 0;
                while (idx >= off + 10 * q_bdiv[f]) begin
                    off += 10 * q_bdiv[f];
                    f++;
                end
                exp_tx = frame_bit(q_bytes[f], (idx - off) / q_bdiv[f]);
            end
            check($sformatf("tx_k%0d", k), tx, exp_tx);
            check($sformatf("irq_k%0d", k), irq, IRQ_BUILD && irq_en && k == 0);
            if (k == probe_k) check_reg("status_probe", A_STATUS, probe_exp);
            if (k <= total) @(negedge clk);
        end
        check_reg("status_idle", A_STATUS, 32'h02 | ((IRQ_BUILD && irq_en) ? 32'h20 : 32'h0));
    endtask

    initial begin
        logic [7:0] b;
        int         bd;
        int         lows;

        bus.Sel = 1'b0; bus.Ad = '0; bus.WrData = '0; bus.MemWr = 3'b000;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("tx_in_reset", tx, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check("tx_reset", tx, 1'b1);
        check("irq_reset", irq, 1'b0);
        check_reg("status_reset", A_STATUS, 32'h02);
        check_reg("baud_reset", A_BAUD, 32'd434);
        check_reg("txdata_read", A_TXDATA, 32'h0);
        check_reg("rsvd_read", A_RSVD, 32'h0);
        bus.Sel = 1'b0; bus.Ad = A_BAUD;
        #1 check("dm_unselected", bus.DM, 32'h0);

        // Single frame 0xA5 at divider 4
        bus_wr(A_BAUD, 32'd4); bus_idle();
        bus_wr(A_TXDATA, 32'hA5); bus_idle();
        q_bytes = '{8'hA5}; q_bdiv = '{4};
        check_stream(0, 1'b0, -1, 32'h0);

        // Random frames with random dividers
        for (int i = 0; i < 4; i++) begin
            b  = 8'($urandom);
            bd = int'($urandom_range(2, 5));
            bus_wr(A_BAUD, 32'(bd)); bus_idle();
            check_reg("baud_rand", A_BAUD, 32'(bd));
            bus_wr(A_TXDATA, {24'($urandom), b}); bus_idle();
            q_bytes = '{b}; q_bdiv = '{bd};
            check_stream(0, 1'b0, -1, 32'h0);
        end

        // Divider clamp and full-range readback
        bus_wr(A_BAUD, 32'd0); bus_idle();
        check_reg("baud_clamp0", A_BAUD, 32'd2);
        bus_wr(A_BAUD, 32'hABCD_FFFF); bus_idle();
        check_reg("baud_max", A_BAUD, 32'h0000_FFFF);

        // Three back-to-back frames at divider 2; third pop drains the FIFO
        bus_wr(A_BAUD, 32'd2); bus_idle();
        bus_wr(A_TXDATA, 32'h01); bus_wr(A_TXDATA, 32'h02); bus_wr(A_TXDATA, 32'h03); bus_idle();
        q_bytes = '{8'h01, 8'h02, 8'h03}; q_bdiv = '{2, 2, 2};
        check_stream(2, 1'b0, 41, 32'h06);

        // Overflow with the transmitter stalled on a very slow frame
        bus_wr(A_BAUD, 32'hFFFF);
        for (int i = 0; i < 9; i++) bus_wr(A_TXDATA, 32'(8'h10 + i));
        bus_idle();
        check_reg("status_full", A_STATUS, 32'h05);
        bus_wr(A_TXDATA, 32'hEE); bus_idle();
        check_reg("status_ovf", A_STATUS, 32'h0D);
        bus_wr(A_STATUS, 32'h0); bus_idle();
        check_reg("status_ovf_clr", A_STATUS, 32'h05);
        rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
        check_reg("status_after_rst1", A_STATUS, 32'h02);

        // Reset during data bit 3 with a second byte queued
        bus_wr(A_BAUD, 32'd4); bus_idle();
        bus_wr(A_TXDATA, 32'h00); bus_wr(A_TXDATA, 32'h55); bus_idle();
        repeat (17) @(negedge clk);
        check("tx_bit3_low", tx, 1'b0);
        rst = 1'b1;
        #1 check("tx_async_rst", tx, 1'b1);
        @(negedge clk); rst = 1'b0;
        check_reg("status_after_rst2", A_STATUS, 32'h02);
        check_reg("baud_after_rst2", A_BAUD, 32'd434);
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("no_frame_after_rst", 32'(lows), 32'd0);

        // Divider change mid-frame applies to the next frame only
        bus_wr(A_BAUD, 32'd4); bus_idle();
        b = 8'($urandom);
        bus_wr(A_TXDATA, 32'h3C); bus_wr(A_TXDATA, {24'h0, b}); bus_wr(A_BAUD, 32'd8); bus_idle();
        q_bytes = '{8'h3C, b}; q_bdiv = '{4, 8};
        check_stream(2, 1'b0, -1, 32'h0);
        bus_wr(A_BAUD, 32'd1); bus_idle();
        check_reg("baud_clamp1", A_BAUD, 32'd2);

        // Interrupt enable and idle interrupt
        bus_wr(A_STATUS, 32'h20); bus_idle();
        check_reg("status_irq_en", A_STATUS, IRQ_BUILD ? 32'h22 : 32'h02);
        @(negedge clk);
        check("irq_idle", irq, IRQ_BUILD);
        b = 8'($urandom);
        bus_wr(A_TXDATA, {24'h0, b}); bus_idle();
        q_bytes = '{b}; q_bdiv = '{2};
        check_stream(0, 1'b1, -1, 32'h0);
        @(negedge clk);
        check("irq_after_stop", irq, IRQ_BUILD);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
